// File: rtl/n3_gtp_encap_pkg.sv
// Shared typedefs and constants for the N3 GTP-U downlink encapsulator.
package n3_gtp_encap_pkg;

    typedef enum logic [2:0] {
        ENC_IDLE    = 3'd0,
        ENC_CSUM    = 3'd1,
        ENC_HDR     = 3'd2,
        ENC_PAYLOAD = 3'd3,
        ENC_DRAIN   = 3'd4,
        ENC_DROP    = 3'd5
    } N3_ENC_STATES;

    localparam logic [15:0] GTPU_UDP_PORT    = 16'd2152;
    localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  GTP_FLAGS_E      = 8'h34;
    localparam logic [7:0]  GTP_MSG_TPDU     = 8'hFF;
    localparam logic [7:0]  GTP_EXT_PDU_SESS = 8'h85;
    localparam int          N3_ENC_HDR_BYTES = 58;

    // Fixed outer IPv4 fields and the length offsets of each outer layer
    // relative to the inner packet length L.
    localparam logic [15:0] IPV4_VER_IHL_TOS = 16'h4500;
    localparam logic [15:0] IPV4_FLAGS_DF    = 16'h4000;
    localparam logic [7:0]  IPV4_PROTO_UDP   = 8'd17;
    localparam logic [15:0] IPV4_LEN_OFS     = 16'd44;
    localparam logic [15:0] UDP_LEN_OFS      = 16'd24;
    localparam logic [15:0] GTP_LEN_OFS      = 16'd8;

endpackage

// File: rtl/n3_gtp_encap_csum.sv
// Serial one's-complement IPv4 header checksum: one 16-bit word per cycle
// for ten cycles after start, result valid with done on the eleventh.
module ipv4_csum_serial (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] word_i,
    output logic [3:0]  word_idx_o,
    output logic        done_o,
    output logic [15:0] csum_o
);
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic [19:0] acc_q;
    logic [19:0] fold1;
    logic [15:0] fold2;

    // Word counter and busy flag; cycle 10 is the fold/result cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd10) busy_q <= 1'b0;
        end
    end

    // 20-bit accumulator holds up to ten 16-bit words without losing carries.
    always_ff @(posedge clk) begin
        if (start_i)                        acc_q <= '0;
        else if (busy_q && cnt_q < 4'd10)   acc_q <= acc_q + {4'b0, word_i};
    end

    // Two carry folds always suffice for ten words, then invert.
    always_comb begin
        fold1  = {4'b0, acc_q[15:0]} + {16'b0, acc_q[19:16]};
        fold2  = fold1[15:0] + {12'b0, fold1[19:16]};
        csum_o = ~fold2;
    end

    assign word_idx_o = cnt_q;
    assign done_o     = busy_q && (cnt_q == 4'd10);

endmodule

// File: rtl/n3_gtp_encap.sv
// Downlink GTP-U encapsulator: prepends Ethernet/IPv4/UDP/GTP-U + PDU Session
// Container header (58 bytes) to an inner IPv4 byte stream.
module n3_gtp_encap
    import n3_gtp_encap_pkg::*;
#(
    parameter logic [47:0] SRC_MAC = 48'h02_00_00_00_00_01,
    parameter logic [47:0] DST_MAC = 48'h02_00_00_00_00_02,
    parameter logic [31:0] SRC_IP  = 32'h0A00_0001,
    parameter logic [31:0] DST_IP  = 32'h0A00_0002,
    parameter logic [7:0]  TTL     = 8'd64,
    parameter logic [15:0] MAX_LEN = 16'd1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [15:0] desc_len,
    input  logic [31:0] desc_teid,
    input  logic [5:0]  desc_qfi,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        err_len,
    output logic [15:0] drop_cnt
);
    N3_ENC_STATES state_q, state_d;
    logic [5:0]   hdr_idx_q, hdr_idx_d;
    logic [15:0]  pay_cnt_q, pay_cnt_d, pay_next;
    logic [15:0]  ip_id_q, ip_id_d;
    logic [15:0]  drop_cnt_q, drop_cnt_d;
    logic         err_q, err_d;
    logic         desc_ready_q;
    logic [7:0]   m_data_q, m_data_d;
    logic [15:0]  len_q, csum_q;
    logic [31:0]  teid_q;
    logic [5:0]   qfi_q;
    logic         accept, csum_start, csum_done;
    logic [3:0]   csum_idx;
    logic [15:0]  csum_word, csum_val;

    function automatic logic [15:0] ip_word(input logic [3:0] idx, input logic [15:0] len,
                                            input logic [15:0] id);
        case (idx)
            4'd0:    return IPV4_VER_IHL_TOS;
            4'd1:    return len + IPV4_LEN_OFS;
            4'd2:    return id;
            4'd3:    return IPV4_FLAGS_DF;
            4'd4:    return {TTL, IPV4_PROTO_UDP};
            4'd6:    return SRC_IP[31:16];
            4'd7:    return SRC_IP[15:0];
            4'd8:    return DST_IP[31:16];
            4'd9:    return DST_IP[15:0];
            default: return 16'h0000;   // word 5 is the checksum itself
        endcase
    endfunction

    // Header serialized byte by byte in wire order.
    function automatic logic [7:0] hdr_byte(input logic [5:0] idx, input logic [15:0] len,
                                            input logic [15:0] id, input logic [15:0] csum,
                                            input logic [31:0] teid, input logic [5:0] qfi);
        logic [15:0] tot, udp, gtp;
        int k;
        k   = int'(idx);
        tot = len + IPV4_LEN_OFS;
        udp = len + UDP_LEN_OFS;
        gtp = len + GTP_LEN_OFS;
        if (k < 6)                  return 8'(DST_MAC >> (8 * (5 - k)));
        else if (k < 12)            return 8'(SRC_MAC >> (8 * (11 - k)));
        else if (k >= 26 && k < 30) return 8'(SRC_IP >> (8 * (29 - k)));
        else if (k >= 30 && k < 34) return 8'(DST_IP >> (8 * (33 - k)));
        else if (k >= 46 && k < 50) return 8'(teid >> (8 * (49 - k)));
        case (k)
            12:      return ETHERTYPE_IPV4[15:8];
            13:      return ETHERTYPE_IPV4[7:0];
            14:      return IPV4_VER_IHL_TOS[15:8];
            16:      return tot[15:8];
            17:      return tot[7:0];
            18:      return id[15:8];
            19:      return id[7:0];
            20:      return IPV4_FLAGS_DF[15:8];
            22:      return TTL;
            23:      return IPV4_PROTO_UDP;
            24:      return csum[15:8];
            25:      return csum[7:0];
            34, 36:  return GTPU_UDP_PORT[15:8];
            35, 37:  return GTPU_UDP_PORT[7:0];
            38:      return udp[15:8];
            39:      return udp[7:0];
            42:      return GTP_FLAGS_E;
            43:      return GTP_MSG_TPDU;
            44:      return gtp[15:8];
            45:      return gtp[7:0];
            53:      return GTP_EXT_PDU_SESS;
            54:      return 8'h01;
            56:      return {2'b00, qfi};
            default: return 8'h00;
        endcase
    endfunction

    assign accept    = (state_q == ENC_IDLE) && desc_valid && desc_ready_q;
    assign pay_next  = pay_cnt_q + 16'd1;
    assign csum_word = ip_word(csum_idx, len_q, ip_id_q);

    ipv4_csum_serial u_csum (
        .clk        (clk),
        .rst        (rst),
        .start_i    (csum_start),
        .word_i     (csum_word),
        .word_idx_o (csum_idx),
        .done_o     (csum_done),
        .csum_o     (csum_val)
    );

    // Next-state and counter update logic for the packet FSM.
    always_comb begin
        state_d    = state_q;
        hdr_idx_d  = hdr_idx_q;
        pay_cnt_d  = pay_cnt_q;
        ip_id_d    = ip_id_q;
        drop_cnt_d = drop_cnt_q;
        m_data_d   = m_data_q;
        err_d      = 1'b0;
        csum_start = 1'b0;
        case (state_q)
            ENC_IDLE: if (accept) begin
                hdr_idx_d = '0;
                pay_cnt_d = '0;
                if (desc_len >= 16'd20 && desc_len <= MAX_LEN) begin
                    state_d    = ENC_CSUM;
                    csum_start = 1'b1;
                end else begin
                    state_d = ENC_DROP;
                    err_d   = 1'b1;
                    if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
            ENC_CSUM: if (csum_done) begin
                state_d  = ENC_HDR;
                m_data_d = hdr_byte(6'd0, len_q, ip_id_q, csum_val, teid_q, qfi_q);
            end
            ENC_HDR: if (m_ready) begin
                if (hdr_idx_q == 6'(N3_ENC_HDR_BYTES - 1)) begin
                    state_d = ENC_PAYLOAD;
                end else begin
                    hdr_idx_d = hdr_idx_q + 6'd1;
                    m_data_d  = hdr_byte(hdr_idx_q + 6'd1, len_q, ip_id_q, csum_q, teid_q, qfi_q);
                end
            end
            ENC_PAYLOAD: if (s_valid && m_ready) begin
                if (s_last) begin
                    state_d = ENC_IDLE;
                    ip_id_d = ip_id_q + 16'd1;
                    err_d   = (pay_next != len_q);
                end else if (pay_next == len_q) begin
                    state_d = ENC_DRAIN;
                    err_d   = 1'b1;
                end else begin
                    pay_cnt_d = pay_next;
                end
            end
            ENC_DRAIN, ENC_DROP: if (s_valid && s_last) state_d = ENC_IDLE;
            default: state_d = ENC_IDLE;
        endcase
    end

    // Control state, counters and the registered header byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ENC_IDLE;
            hdr_idx_q    <= '0;
            pay_cnt_q    <= '0;
            ip_id_q      <= '0;
            drop_cnt_q   <= '0;
            err_q        <= 1'b0;
            desc_ready_q <= 1'b0;
            m_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            hdr_idx_q    <= hdr_idx_d;
            pay_cnt_q    <= pay_cnt_d;
            ip_id_q      <= ip_id_d;
            drop_cnt_q   <= drop_cnt_d;
            err_q        <= err_d;
            desc_ready_q <= (state_d == ENC_IDLE);
            m_data_q     <= m_data_d;
        end
    end

    // Per-packet descriptor fields and the finished checksum.
    always_ff @(posedge clk) begin
        if (accept) begin
            len_q  <= desc_len;
            teid_q <= desc_teid;
            qfi_q  <= desc_qfi;
        end
        if (csum_done) csum_q <= csum_val;
    end

    // Output steering: registered header, combinational payload pass-through.
    always_comb begin
        m_valid = 1'b0;
        m_data  = m_data_q;
        m_last  = 1'b0;
        s_ready = 1'b0;
        case (state_q)
            ENC_HDR: m_valid = 1'b1;
            ENC_PAYLOAD: begin
                m_valid = s_valid;
                m_data  = s_data;
                s_ready = m_ready;
                m_last  = s_valid && (s_last || (pay_next == len_q));
            end
            ENC_DRAIN, ENC_DROP: s_ready = 1'b1;
            default: ;
        endcase
    end

    assign desc_ready = desc_ready_q;
    assign err_len    = err_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_n3_gtp_encap.sv
// Directed bench for n3_gtp_encap: table of packet vectors plus hand-written
// back-to-back and reset-during-header sequences.
module tb_n3_gtp_encap;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        desc_valid = 1'b0, desc_ready;
    logic [15:0] desc_len = '0;
    logic [31:0] desc_teid = '0;
    logic [5:0]  desc_qfi = '0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [7:0]  m_data;
    logic        m_valid, m_last;
    logic        m_ready = 1'b1;
    logic        err_len;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    n3_gtp_encap dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_len(desc_len),
        .desc_teid(desc_teid), .desc_qfi(desc_qfi),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .err_len(err_len), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [15:0] len;
        logic [31:0] teid;
        logic [5:0]  qfi;
        int          n_in;
        int          last_at;
        bit          stall;
        int          exp_out;
        int          exp_mlast;
        int          exp_err;
        logic [15:0] exp_id;
        int          exp_drop;
        logic [7:0]  seed;
    } vec_t;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, first_mv = -1, err_n = 0;
    bit stream_done = 1'b0;
    logic [7:0] out_q[$];
    logic [7:0] exp_q[$];
    int mlast_q[$];
    int mlast_cyc_q[$];
    int acc_q[$];
    vec_t vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe handshakes mid-cycle, when DUT outputs are settled.
    always @(negedge clk) begin
        if (m_valid && first_mv < 0) first_mv = cyc;
        if (m_valid && m_ready) begin
            out_q.push_back(m_data);
            if (m_last) begin
                mlast_q.push_back(out_q.size());
                mlast_cyc_q.push_back(cyc);
            end
        end
        if (err_len) err_n++;
        if (desc_valid && desc_ready) acc_q.push_back(cyc);
    end

    task automatic clear_mon();
        out_q.delete(); mlast_q.delete(); mlast_cyc_q.delete(); acc_q.delete();
        first_mv = -1; err_n = 0;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [7:0] seed, input int i);
        return 8'(i * 7) + seed;
    endfunction

    function automatic logic [7:0] ob(input int k);
        return (k < out_q.size()) ? out_q[k] : 8'h00;
    endfunction

    // Reference frame built field by field; checksum from the assembled header bytes.
    function automatic void build_exp(input logic [15:0] len, input logic [31:0] teid,
                                      input logic [5:0] qfi, input logic [15:0] id,
                                      input int npay, input logic [7:0] seed);
        logic [7:0]  h[58];
        logic [15:0] tot, udp, gtp;
        logic [31:0] s;
        tot = len + 16'd44; udp = len + 16'd24; gtp = len + 16'd8;
        h = '{default: 8'h00};
        h[0] = 8'h02; h[5] = 8'h02; h[6] = 8'h02; h[11] = 8'h01;
        h[12] = 8'h08; h[14] = 8'h45;
        h[16] = tot[15:8]; h[17] = tot[7:0]; h[18] = id[15:8]; h[19] = id[7:0];
        h[20] = 8'h40; h[22] = 8'd64; h[23] = 8'd17;
        h[26] = 8'h0A; h[29] = 8'h01; h[30] = 8'h0A; h[33] = 8'h02;
        h[34] = 8'h08; h[35] = 8'h68; h[36] = 8'h08; h[37] = 8'h68;
        h[38] = udp[15:8]; h[39] = udp[7:0];
        h[42] = 8'h34; h[43] = 8'hFF; h[44] = gtp[15:8]; h[45] = gtp[7:0];
        h[46] = teid[31:24]; h[47] = teid[23:16]; h[48] = teid[15:8]; h[49] = teid[7:0];
        h[53] = 8'h85; h[54] = 8'h01; h[56] = {2'b00, qfi};
        s = 0;
        for (int k = 14; k < 34; k += 2) s = s + {16'h0, h[k], h[k+1]};
        while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        h[24] = ~s[15:8]; h[25] = ~s[7:0];
        exp_q.delete();
        for (int k = 0; k < 58; k++) exp_q.push_back(h[k]);
        for (int i = 0; i < npay; i++) exp_q.push_back(pat(seed, i));
    endfunction

    task automatic cmp_frame(input string name, input int off);
        int bad = 0, first = -1;
        logic [7:0] a;
        n_chk++;
        for (int k = 0; k < exp_q.size(); k++) begin
            a = ob(off + k);
            if (a !== exp_q[k]) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: %0d bytes differ, first at byte %0d got 0x%02h expected 0x%02h",
                     name, bad, first, ob(off + first), exp_q[first]);
        end
    endtask

    task automatic drive_desc(input logic [15:0] len, input logic [31:0] teid, input logic [5:0] qfi);
        int g = 0;
        bit done = 1'b0;
        desc_valid = 1'b1; desc_len = len; desc_teid = teid; desc_qfi = qfi;
        while (!done && g < 5000) begin
            @(negedge clk);
            if (desc_ready) done = 1'b1;
            @(posedge clk); #1;
            g++;
        end
        desc_valid = 1'b0;
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL desc_timeout: descriptor len %0d not accepted after %0d cycles", len, g);
        end
    endtask

    task automatic drive_stream(input int n, input int last_at, input bit stall, input logic [7:0] seed);
        int i = 0, g = 0;
        while (i < n && g < 20000) begin
            s_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data  = pat(seed, i);
            s_last  = (i + 1 == last_at);
            @(negedge clk);
            if (s_valid && s_ready) i++;
            @(posedge clk); #1;
            g++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (i < n) begin
            n_chk++; n_fail++;
            $display("FAIL stream_timeout: %0d of %0d bytes consumed", i, n);
        end
        stream_done = 1'b1;
    endtask

    task automatic run_pkt(input vec_t v, input string tag);
        clear_mon();
        stream_done = 1'b0;
        fork
            drive_desc(v.len, v.teid, v.qfi);
            drive_stream(v.n_in, v.last_at, v.stall, v.seed);
            begin
                int g = 0;
                while (!stream_done && g < 25000) begin
                    m_ready = v.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                    @(posedge clk); #1;
                    g++;
                end
                m_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_out_bytes"}, out_q.size(), v.exp_out);
        chk({tag, "_mlast_count"}, mlast_q.size(), (v.exp_mlast > 0) ? 1 : 0);
        if (mlast_q.size() > 0) chk({tag, "_mlast_pos"}, mlast_q[0], v.exp_mlast);
        chk({tag, "_err_pulses"}, err_n, v.exp_err);
        chk({tag, "_drop_cnt"}, drop_cnt, v.exp_drop);
        if (v.exp_out > 0) begin
            build_exp(v.len, v.teid, v.qfi, v.exp_id, v.exp_out - 58, v.seed);
            cmp_frame({tag, "_frame"}, 0);
            if (acc_q.size() > 0) chk({tag, "_latency"}, first_mv - acc_q[0], 12);
        end
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{16'd100,  32'hA5A5_0001, 6'd1,  100,  100,  1'b0, 158,  158,  0, 16'd2, 0, 8'h11};
        vecs[1] = '{16'd100,  32'hA5A5_0001, 6'd1,  100,  100,  1'b1, 158,  158,  0, 16'd3, 0, 8'h11};
        vecs[2] = '{16'd30,   32'h0000_0030, 6'd7,  25,   25,   1'b0, 83,   83,   1, 16'd4, 0, 8'h22};
        vecs[3] = '{16'd10,   32'h0000_0010, 6'd2,  10,   10,   1'b0, 0,    0,    1, 16'd0, 1, 8'h33};
        vecs[4] = '{16'd1501, 32'h0000_0011, 6'd2,  5,    5,    1'b0, 0,    0,    1, 16'd0, 2, 8'h44};
        vecs[5] = '{16'd19,   32'h0000_0012, 6'd2,  3,    3,    1'b0, 0,    0,    1, 16'd0, 3, 8'h55};
        vecs[6] = '{16'd20,   32'h0BAD_F00D, 6'd21, 20,   20,   1'b0, 78,   78,   0, 16'd5, 3, 8'h66};
        vecs[7] = '{16'd1500, 32'hCAFE_BABE, 6'd63, 1500, 1500, 1'b0, 1558, 1558, 0, 16'd6, 3, 8'h77};
        vecs[8] = '{16'd30,   32'h0000_0040, 6'd5,  40,   40,   1'b0, 88,   88,   1, 16'd7, 3, 8'h88};
        vecs[9] = '{16'd20,   32'h0000_0099, 6'd4,  20,   20,   1'b0, 78,   78,   0, 16'd0, 0, 8'h99};

        // Reset values
        #23;
        chk("rst_desc_ready", desc_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_desc_ready", desc_ready, 1);

        // Two back-to-back L=20 packets with the reference constants
        clear_mon();
        fork
            begin drive_desc(16'd20, 32'h0000_1234, 6'd9); drive_desc(16'd20, 32'h0000_1234, 6'd9); end
            begin drive_stream(20, 20, 1'b0, 8'h10); drive_stream(20, 20, 1'b0, 8'h20); end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_out_bytes", out_q.size(), 156);
        chk("b2b_mlast_count", mlast_q.size(), 2);
        if (mlast_q.size() == 2) begin
            chk("b2b_mlast_pos1", mlast_q[0], 78);
            chk("b2b_mlast_pos2", mlast_q[1], 156);
        end
        if (acc_q.size() > 0) chk("b2b_latency", first_mv - acc_q[0], 12);
        chk("b2b_ip_total", {ob(16), ob(17)}, 16'h0040);
        chk("b2b_ip_csum1", {ob(24), ob(25)}, 16'h26AB);
        chk("b2b_udp_len", {ob(38), ob(39)}, 16'h002C);
        chk("b2b_gtp_len", {ob(44), ob(45)}, 16'h001C);
        chk("b2b_qfi_byte", ob(56), 8'h09);
        chk("b2b_ip_id2", {ob(78 + 18), ob(78 + 19)}, 16'h0001);
        chk("b2b_ip_csum2", {ob(78 + 24), ob(78 + 25)}, 16'h26AA);
        chk("b2b_accepts", acc_q.size(), 2);
        if (acc_q.size() == 2 && mlast_cyc_q.size() > 0)
            chk("b2b_accept_gap", acc_q[1] - mlast_cyc_q[0], 1);
        chk("b2b_err", err_n, 0);
        build_exp(16'd20, 32'h0000_1234, 6'd9, 16'd0, 20, 8'h10);
        cmp_frame("b2b_frame1", 0);
        build_exp(16'd20, 32'h0000_1234, 6'd9, 16'd1, 20, 8'h20);
        cmp_frame("b2b_frame2", 78);

        // Table of single-packet vectors (normal, stalls, early end, drops, max, overrun)
        for (int i = 0; i < 9; i++) run_pkt(vecs[i], $sformatf("v%0d", i));

        // Reset asserted while the header is being emitted
        clear_mon();
        drive_desc(16'd20, 32'h0000_0077, 6'd3);
        for (int g = 0; g < 100 && out_q.size() < 10; g++) @(posedge clk);
        chk("hdr_reached", (out_q.size() >= 10) ? 1 : 0, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_last", m_last, 0);
        chk("mid_rst_desc_ready", desc_ready, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_err_len", err_len, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_drop_cnt", drop_cnt, 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rv = vecs[9];
        run_pkt(rv, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/n3_gtp_encap.md
# n3_gtp_encap

Downlink GTP-U encapsulator: the transmit-side counterpart of the N3 parser. It takes an inner IPv4 packet as a byte stream plus a per-packet descriptor (length, TEID, QFI). It emits a complete N3 frame in wire order: Ethernet/IPv4/UDP/GTP-U header with a PDU Session Container extension, followed by the unmodified inner packet. It sits between the N6-side classifier/forwarding stage and the N3 MAC transmit interface.

## Interface
- `SRC_MAC`, 48'h02_00_00_00_00_01, outer Ethernet source.
- `DST_MAC`, 48'h02_00_00_00_00_02, outer Ethernet destination.
- `SRC_IP`, 32'h0A00_0001, outer IPv4 source.
- `DST_IP`, 32'h0A00_0002, outer IPv4 destination.
- `TTL`, 8'd64, outer IPv4 TTL.
- `MAX_LEN`, 16'd1500, largest accepted inner length in bytes. Must be ≤ 65491.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `desc_valid` in 1 / `desc_ready` out 1: descriptor handshake.
- `desc_len` in 16: inner packet length L in bytes.
- `desc_teid` in 32: GTP TEID.
- `desc_qfi` in 6: QoS flow identifier.
- `s_data` in 8, `s_valid` in 1, `s_last` in 1, `s_ready` out 1: inner byte stream.
- `m_data` out 8, `m_valid` out 1, `m_last` out 1, `m_ready` in 1: N3 frame byte stream.
- `err_len` out 1: one-cycle pulse when there is a length mismatch or a packet is dropped.
- `drop_cnt` out 16: count of dropped packets. Saturates at 16'hFFFF.

## Operation
- States: IDLE, CSUM, HDR, PAYLOAD, DRAIN, DROP.
- **IDLE**
  - `desc_ready`=1.
  - On `desc_valid`&&`desc_ready`, latch L, TEID and QFI.
  - If 20 ≤ L ≤ MAX_LEN, go to CSUM. Otherwise go to DROP.
- **CSUM**
  - Serially sum the ten 16-bit outer IPv4 header words, one per cycle, into a 20-bit accumulator. The checksum word is taken as 0.
  - On the 11th cycle, fold the carries twice and invert. Then go to HDR.
- **HDR**: emit the 58 header bytes, indexed 0..57 by a counter. The counter advances on `m_valid`&&`m_ready`.
  - Ethernet: DST_MAC, SRC_MAC, 16'h0800.
  - IPv4:
    - Fixed fields: 8'h45; TOS 0; total length L+44; identification `ip_id`.
    - 16'h4000: flags=DF in the upper 3 bits, fragment offset 0.
    - TTL; protocol 17; checksum; SRC_IP; DST_IP.
  - UDP: source port 2152, destination port 2152, length L+24, checksum 0.
  - GTP-U:
    - Fixed fields: flags 8'h34; message type 8'hFF; length L+8; TEID.
    - Optional fields: sequence 16'h0000; N-PDU 8'h00; next extension type 8'h85.
  - PDU Session Container: 8'h01, 8'h00, {2'b00, QFI}, 8'h00.
  - After byte 57 transfers, go to PAYLOAD.
- **PAYLOAD**
  - Combinational pass-through: `m_data`=`s_data`, `m_valid`=`s_valid`, `s_ready`=`m_ready`.
  - A 16-bit counter tracks transferred bytes.
  - Normal end: byte L carries `s_last`. `m_last`=1 on that byte, then go to IDLE and increment `ip_id` (wraps 16'hFFFF→0).
  - Early `s_last` on byte n<L: `m_last`=1 on byte n, `err_len` pulses, go to IDLE, and `ip_id` increments.
  - Byte L arrives without `s_last`: force `m_last`=1 on byte L, `err_len` pulses, go to DRAIN.
- **DRAIN**: `s_ready`=1 and `m_valid`=0. Discard bytes through `s_last`, then go to IDLE.
- **DROP**
  - On entry, `err_len` pulses once and `drop_cnt` increments.
  - `s_ready`=1 and `m_valid`=0. Discard through `s_last`, then go to IDLE. `ip_id` is unchanged.
- Outside HDR and PAYLOAD: `m_valid`=0. Outside PAYLOAD, DRAIN and DROP: `s_ready`=0.

## Timing
- Reset values:
  - State IDLE.
  - `desc_ready`, `m_valid`, `m_last`, `s_ready`, `err_len` all 0. `m_data` 0.
  - `ip_id` 0, `drop_cnt` 0.
- `desc_ready` is registered: 0 while `rst` is high, 1 from the first IDLE cycle after deassertion.
- Latency: descriptor accepted at cycle T → CSUM at T+1..T+11 → header byte 0 presented with `m_valid`=1 at T+12.
- HDR bytes are registered and held stable while `m_ready`=0.
- Throughput: one byte per cycle with `m_ready`=1.
- Back-to-back packets: the next descriptor is accepted in the cycle after the previous `m_last` transfer, so there is one IDLE cycle per packet.
- `s_valid` before a descriptor is not consumed (`s_ready`=0).
- Reset mid-packet: return to IDLE immediately. The frame is truncated with no `m_last`, and the counters clear.
- All length arithmetic is 16-bit. The MAX_LEN bound guarantees no overflow.

## Structure
- Add to the shared typedefs package:
  - enum `N3_ENC_STATES`.
  - Constants `GTPU_UDP_PORT`=2152, `ETHERTYPE_IPV4`=16'h0800, `GTP_FLAGS_E`=8'h34, `GTP_MSG_TPDU`=8'hFF, `GTP_EXT_PDU_SESS`=8'h85, `N3_ENC_HDR_BYTES`=58.
- Header bytes are serialized explicitly in wire order (IPv4 flags before fragment offset). Do not use a bit-cast of the existing IPv4 struct.
- Sub-module `ipv4_csum_serial`: word-in / start / done one's-complement unit, 11 cycles per checksum.

## Test plan
- L=20, TEID=32'h0000_1234, QFI=9, defaults, `m_ready`=1:
  - 78 bytes out; header byte 0 at T+12.
  - IPv4 total 16'h0040, checksum 16'h26AB; UDP length 16'h002C; GTP length 16'h001C.
  - Byte 56 is 8'h09. `m_last` on byte 78.
- Two back-to-back packets: second IPv4 identification 16'h0001, second checksum 16'h26AA.
- Random `m_ready` and `s_valid` stalls on an L=100 packet: output bytes identical to the no-stall run.
- L=30 with `s_last` on byte 25:
  - `m_last` on output byte 58+25.
  - `err_len` one pulse; next descriptor accepted.
- L=30 with 40 input bytes: `m_last` on byte 58+30, remaining 10 bytes drained, `err_len` pulse.
- L=10 and L=MAX_LEN+1: no `m_valid`, inputs drained, `drop_cnt`=2, `ip_id` unchanged. Reset asserted during HDR returns all outputs to reset values.
